// File: rtl/rvfi_reg_source.sv
// -----------------------------------------------------------------------------
// rvfi_reg_source
//
// Golden RVFI retirement-trace generator. Accepts abstract retire requests on
// NRET channels and keeps its own architectural register file. One cycle later
// it emits RVFI packets whose rs1/rs2 read data match every earlier write,
// including writes from lower-indexed channels retiring in the same cycle.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   init_value        reset value for x1..x31 when ZERO_INIT=0
//   stall             blocks acceptance of every channel this cycle
//   req_valid         per-channel retire request (index = program order)
//   req_insn          instruction word per channel
//   req_rs1_addr      source 1 index per channel
//   req_rs2_addr      source 2 index per channel
//   req_rd_addr       destination index per channel
//   req_rd_wdata      destination write value per channel
//   req_ready         = !stall && !reset
//   rvfi_*            registered RVFI retirement packet, one cycle latency
// -----------------------------------------------------------------------------
module rvfi_reg_source #(
    parameter int NRET      = 1,
    parameter int XLEN      = 32,
    parameter bit ZERO_INIT = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [XLEN-1:0]      init_value,
    input  logic                 stall,
    input  logic [NRET-1:0]      req_valid,
    input  logic [32*NRET-1:0]   req_insn,
    input  logic [5*NRET-1:0]    req_rs1_addr,
    input  logic [5*NRET-1:0]    req_rs2_addr,
    input  logic [5*NRET-1:0]    req_rd_addr,
    input  logic [XLEN*NRET-1:0] req_rd_wdata,
    output logic                 req_ready,
    output logic [NRET-1:0]      rvfi_valid,
    output logic [64*NRET-1:0]   rvfi_order,
    output logic [32*NRET-1:0]   rvfi_insn,
    output logic [5*NRET-1:0]    rvfi_rs1_addr,
    output logic [5*NRET-1:0]    rvfi_rs2_addr,
    output logic [5*NRET-1:0]    rvfi_rd_addr,
    output logic [XLEN*NRET-1:0] rvfi_rs1_rdata,
    output logic [XLEN*NRET-1:0] rvfi_rs2_rdata,
    output logic [XLEN*NRET-1:0] rvfi_rd_wdata
);

    // Architectural register file. Entry 0 is held at zero and never written,
    // so reads of x0 are also masked explicitly below.
    logic [XLEN-1:0] regs [32];
    logic [63:0]     order_q;

    // Stage p0: combinational acceptance, forwarding and order assignment
    logic [NRET-1:0] vld_p0;
    logic [XLEN-1:0] rs1_rdata_p0 [NRET];
    logic [XLEN-1:0] rs2_rdata_p0 [NRET];
    logic [XLEN-1:0] rd_wdata_p0  [NRET];
    logic [63:0]     order_p0     [NRET];
    logic [63:0]     order_next_p0;

    assign req_ready = !stall && !reset;

    always_comb begin
        logic [4:0] a1, a2, rdj;
        order_next_p0 = order_q;
        vld_p0        = '0;
        for (int c = 0; c < NRET; c++) begin
            rs1_rdata_p0[c] = '0;
            rs2_rdata_p0[c] = '0;
            rd_wdata_p0[c]  = '0;
            order_p0[c]     = '0;
        end
        for (int c = 0; c < NRET; c++) begin
            vld_p0[c] = req_valid[c] && req_ready;
            a1 = req_rs1_addr[5*c +: 5];
            a2 = req_rs2_addr[5*c +: 5];
            rs1_rdata_p0[c] = (a1 == 5'd0) ? '0 : regs[a1];
            rs2_rdata_p0[c] = (a2 == 5'd0) ? '0 : regs[a2];
            // Forward writes from earlier accepted channels; scanning upward
            // lets the highest-index earlier writer win. Channel c itself is
            // excluded so its own write never reaches its own sources.
            for (int j = 0; j < NRET; j++) begin
                rdj = req_rd_addr[5*j +: 5];
                if (j < c && vld_p0[j] && rdj != 5'd0) begin
                    if (rdj == a1) rs1_rdata_p0[c] = req_rd_wdata[XLEN*j +: XLEN];
                    if (rdj == a2) rs2_rdata_p0[c] = req_rd_wdata[XLEN*j +: XLEN];
                end
            end
            if (req_rd_addr[5*c +: 5] != 5'd0)
                rd_wdata_p0[c] = req_rd_wdata[XLEN*c +: XLEN];
            // Skipped channels consume no order number.
            if (vld_p0[c]) begin
                order_p0[c]   = order_next_p0;
                order_next_p0 = order_next_p0 + 64'd1;
            end
        end
    end

    // Stage p1: registered RVFI packet and architectural state update
    always_ff @(posedge clock) begin
        if (reset) begin
            rvfi_valid     <= '0;
            rvfi_order     <= '0;
            rvfi_insn      <= '0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd_wdata  <= '0;
            order_q        <= '0;
            regs[0]        <= '0;
            for (int r = 1; r < 32; r++)
                regs[r] <= ZERO_INIT ? '0 : init_value;
        end else begin
            order_q <= order_next_p0;
            for (int c = 0; c < NRET; c++) begin
                rvfi_valid[c] <= vld_p0[c];
                if (vld_p0[c]) begin
                    rvfi_order[64*c +: 64]       <= order_p0[c];
                    rvfi_insn[32*c +: 32]        <= req_insn[32*c +: 32];
                    rvfi_rs1_addr[5*c +: 5]      <= req_rs1_addr[5*c +: 5];
                    rvfi_rs2_addr[5*c +: 5]      <= req_rs2_addr[5*c +: 5];
                    rvfi_rd_addr[5*c +: 5]       <= req_rd_addr[5*c +: 5];
                    rvfi_rs1_rdata[XLEN*c +: XLEN] <= rs1_rdata_p0[c];
                    rvfi_rs2_rdata[XLEN*c +: XLEN] <= rs2_rdata_p0[c];
                    rvfi_rd_wdata[XLEN*c +: XLEN]  <= rd_wdata_p0[c];
                end else begin
                    rvfi_order[64*c +: 64]       <= '0;
                    rvfi_insn[32*c +: 32]        <= '0;
                    rvfi_rs1_addr[5*c +: 5]      <= '0;
                    rvfi_rs2_addr[5*c +: 5]      <= '0;
                    rvfi_rd_addr[5*c +: 5]       <= '0;
                    rvfi_rs1_rdata[XLEN*c +: XLEN] <= '0;
                    rvfi_rs2_rdata[XLEN*c +: XLEN] <= '0;
                    rvfi_rd_wdata[XLEN*c +: XLEN]  <= '0;
                end
            end
            // Later channels are written last, so the highest-index writer
            // to a given rd lands in the register file.
            for (int c = 0; c < NRET; c++) begin
                if (vld_p0[c] && req_rd_addr[5*c +: 5] != 5'd0)
                    regs[req_rd_addr[5*c +: 5]] <= req_rd_wdata[XLEN*c +: XLEN];
            end
        end
    end

endmodule

// File: tb/tb_rvfi_reg_source.sv
// -----------------------------------------------------------------------------
// tb_rvfi_reg_source
//
// Drives two instances: A (NRET=2, ZERO_INIT=1) and B (NRET=1, ZERO_INIT=0).
// B receives channel 0 of A's requests. A sequential reference model computes
// expected packets, which are queued per channel and checked by a monitor.
// -----------------------------------------------------------------------------
module tb_rvfi_reg_source;

    typedef struct packed {
        logic        v;
        logic [31:0] insn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] wd;
    } req_t;

    // packet layout: valid, order, insn, rs1, rs2, rd, rs1_rdata, rs2_rdata, rd_wdata
    typedef logic [207:0] pkt_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A signals
    logic         a_reset, a_stall, a_ready;
    logic [31:0]  a_init;
    logic [1:0]   a_req_valid, a_valid;
    logic [63:0]  a_req_insn, a_insn;
    logic [9:0]   a_req_rs1, a_req_rs2, a_req_rd, a_rs1, a_rs2, a_rd;
    logic [63:0]  a_req_wd, a_rs1d, a_rs2d, a_rdw;
    logic [127:0] a_order;

    // Instance B signals
    logic         b_reset, b_stall, b_ready;
    logic [31:0]  b_init;
    logic [0:0]   b_req_valid, b_valid;
    logic [31:0]  b_req_insn, b_insn;
    logic [4:0]   b_req_rs1, b_req_rs2, b_req_rd, b_rs1, b_rs2, b_rd;
    logic [31:0]  b_req_wd, b_rs1d, b_rs2d, b_rdw;
    logic [63:0]  b_order;

    rvfi_reg_source #(.NRET(2), .XLEN(32), .ZERO_INIT(1'b1)) u_a (
        .clock(clock), .reset(a_reset), .init_value(a_init), .stall(a_stall),
        .req_valid(a_req_valid), .req_insn(a_req_insn),
        .req_rs1_addr(a_req_rs1), .req_rs2_addr(a_req_rs2), .req_rd_addr(a_req_rd),
        .req_rd_wdata(a_req_wd), .req_ready(a_ready),
        .rvfi_valid(a_valid), .rvfi_order(a_order), .rvfi_insn(a_insn),
        .rvfi_rs1_addr(a_rs1), .rvfi_rs2_addr(a_rs2), .rvfi_rd_addr(a_rd),
        .rvfi_rs1_rdata(a_rs1d), .rvfi_rs2_rdata(a_rs2d), .rvfi_rd_wdata(a_rdw)
    );

    rvfi_reg_source #(.NRET(1), .XLEN(32), .ZERO_INIT(1'b0)) u_b (
        .clock(clock), .reset(b_reset), .init_value(b_init), .stall(b_stall),
        .req_valid(b_req_valid), .req_insn(b_req_insn),
        .req_rs1_addr(b_req_rs1), .req_rs2_addr(b_req_rs2), .req_rd_addr(b_req_rd),
        .req_rd_wdata(b_req_wd), .req_ready(b_ready),
        .rvfi_valid(b_valid), .rvfi_order(b_order), .rvfi_insn(b_insn),
        .rvfi_rs1_addr(b_rs1), .rvfi_rs2_addr(b_rs2), .rvfi_rd_addr(b_rd),
        .rvfi_rs1_rdata(b_rs1d), .rvfi_rs2_rdata(b_rs2d), .rvfi_rd_wdata(b_rdw)
    );

    int vectors = 0;
    int miscompares = 0;

    pkt_t qa0[$], qa1[$], qb0[$];

    // Reference model state: [0] = instance A, [1] = instance B
    logic [31:0] mreg [2][32];
    logic [63:0] mord [2];

    task automatic check(input string name, input pkt_t act, input pkt_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Sequential reference: each accepted channel reads the register file,
    // then immediately applies its own write, which reproduces program order.
    task automatic model(input int d, input int n, input bit rst, input bit stl,
                         input logic [31:0] init, input req_t r0, input req_t r1);
        req_t rq;
        pkt_t pk;
        logic [31:0] s1, s2, w;
        for (int c = 0; c < n; c++) begin
            rq = (c == 0) ? r0 : r1;
            pk = '0;
            if (!rst && !stl && rq.v) begin
                s1 = (rq.rs1 == 5'd0) ? 32'd0 : mreg[d][rq.rs1];
                s2 = (rq.rs2 == 5'd0) ? 32'd0 : mreg[d][rq.rs2];
                w  = (rq.rd == 5'd0) ? 32'd0 : rq.wd;
                pk = {1'b1, mord[d], rq.insn, rq.rs1, rq.rs2, rq.rd, s1, s2, w};
                mord[d] = mord[d] + 64'd1;
                if (rq.rd != 5'd0) mreg[d][rq.rd] = rq.wd;
            end
            if (d == 1) qb0.push_back(pk);
            else if (c == 0) qa0.push_back(pk);
            else qa1.push_back(pk);
        end
        if (rst) begin
            mord[d] = 64'd0;
            mreg[d][0] = 32'd0;
            for (int r = 1; r < 32; r++) mreg[d][r] = (d == 0) ? 32'd0 : init;
        end
    endtask

    task automatic step(input bit rst, input bit stl, input logic [31:0] init,
                        input req_t r0, input req_t r1);
        @(negedge clock);
        a_reset = rst;  b_reset = rst;
        a_stall = stl;  b_stall = stl;
        a_init  = $urandom;  b_init = init;
        a_req_valid = {r1.v, r0.v};
        a_req_insn  = {r1.insn, r0.insn};
        a_req_rs1   = {r1.rs1, r0.rs1};
        a_req_rs2   = {r1.rs2, r0.rs2};
        a_req_rd    = {r1.rd, r0.rd};
        a_req_wd    = {r1.wd, r0.wd};
        b_req_valid = r0.v;
        b_req_insn  = r0.insn;
        b_req_rs1   = r0.rs1;
        b_req_rs2   = r0.rs2;
        b_req_rd    = r0.rd;
        b_req_wd    = r0.wd;
        model(0, 2, rst, stl, init, r0, r1);
        model(1, 1, rst, stl, init, r0, r1);
        #1;
        check("a_req_ready", {207'd0, a_ready}, {207'd0, !stl && !rst});
        check("b_req_ready", {207'd0, b_ready}, {207'd0, !stl && !rst});
    endtask

    function automatic req_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] wd);
        req_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.wd = wd;
        r.insn = $urandom;
        return r;
    endfunction

    function automatic req_t rnd();
        return mk(($urandom % 4) != 0, 5'($urandom % 8), 5'($urandom % 8),
                  5'($urandom % 8), $urandom);
    endfunction

    // Monitor: compare every cycle for which an expectation was queued.
    initial begin
        pkt_t e;
        forever begin
            @(posedge clock);
            #1;
            if (qa0.size() > 0) begin
                e = qa0.pop_front();
                check("a.ch0", {a_valid[0], a_order[63:0], a_insn[31:0], a_rs1[4:0], a_rs2[4:0],
                                a_rd[4:0], a_rs1d[31:0], a_rs2d[31:0], a_rdw[31:0]}, e);
            end
            if (qa1.size() > 0) begin
                e = qa1.pop_front();
                check("a.ch1", {a_valid[1], a_order[127:64], a_insn[63:32], a_rs1[9:5], a_rs2[9:5],
                                a_rd[9:5], a_rs1d[63:32], a_rs2d[63:32], a_rdw[63:32]}, e);
            end
            if (qb0.size() > 0) begin
                e = qb0.pop_front();
                check("b.ch0", {b_valid[0], b_order, b_insn, b_rs1, b_rs2, b_rd,
                                b_rs1d, b_rs2d, b_rdw}, e);
            end
        end
    end

    initial begin
        req_t z;
        int budget;
        z = '0;
        for (int d = 0; d < 2; d++) begin
            mord[d] = '0;
            for (int r = 0; r < 32; r++) mreg[d][r] = '0;
        end
        a_reset = 1'b1; b_reset = 1'b1; a_stall = 1'b0; b_stall = 1'b0;
        a_init = '0; b_init = '0;
        a_req_valid = '0; a_req_insn = '0; a_req_rs1 = '0; a_req_rs2 = '0;
        a_req_rd = '0; a_req_wd = '0;
        b_req_valid = '0; b_req_insn = '0; b_req_rs1 = '0; b_req_rs2 = '0;
        b_req_rd = '0; b_req_wd = '0;

        // Reset, then write x5 and read it back
        step(1, 0, 32'h55AA55AA, z, z);
        step(1, 0, 32'h55AA55AA, z, z);
        step(0, 0, 0, mk(1, 5, 6, 5, 32'hDEADBEEF), z);
        step(0, 0, 0, mk(1, 5, 0, 1, 32'h1), z);
        // x0 write is discarded and its rd_wdata reads back 0
        step(0, 0, 0, mk(1, 1, 2, 0, 32'h1234), z);
        step(0, 0, 0, mk(1, 0, 0, 2, 32'h2), z);
        // Write x7, reset mid-stream with a pending request, read x7
        step(0, 0, 0, mk(1, 7, 7, 7, 32'hCAFEF00D), z);
        step(1, 0, 32'h55AA55AA, mk(1, 7, 0, 7, 32'h11111111), z);
        step(0, 0, 0, mk(1, 7, 7, 0, 32'h0), z);
        // Same-cycle forwarding from ch0 to ch1, then a read of x3
        step(1, 0, 32'h13579BDF, z, z);
        step(0, 0, 0, mk(1, 0, 0, 3, 32'hA), mk(1, 3, 3, 3, 32'hB));
        step(0, 0, 0, mk(1, 3, 3, 0, 32'h0), z);
        // Mask 10 for three cycles
        step(1, 0, 32'h2468ACE0, z, z);
        for (int i = 0; i < 3; i++) step(0, 0, 0, z, mk(1, 3, 4, 3, $urandom));
        // Stall for two cycles inside a valid stream
        step(0, 0, 0, mk(1, 1, 2, 4, 32'h44), mk(1, 4, 3, 5, 32'h55));
        step(0, 1, 0, mk(1, 4, 5, 4, 32'h99), mk(1, 5, 4, 5, 32'h98));
        step(0, 1, 0, mk(1, 4, 5, 4, 32'h97), mk(1, 5, 4, 5, 32'h96));
        step(0, 0, 0, mk(1, 4, 5, 6, 32'h66), mk(1, 6, 4, 7, 32'h77));
        // Randomized traffic with occasional stalls and resets
        for (int i = 0; i < 3000; i++)
            step(($urandom % 64) == 0, ($urandom % 5) == 0, $urandom, rnd(), rnd());
        step(0, 0, 0, z, z);
        step(0, 0, 0, z, z);

        budget = 20;
        while ((qa0.size() + qa1.size() + qb0.size()) != 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (budget == 0) begin
            miscompares++;
            $display("FAIL drain: %0d packets still pending, required 0",
                     qa0.size() + qa1.size() + qb0.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
